// File: rtl/wb_pkg.sv
// Shared write-back definitions: select codes and the buffered entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_RD_W   = 5;

  // Candidate source indices into the packed in_data bus.
  localparam logic [2:0] WB_SEL_NORMAL = 3'd0;
  localparam logic [2:0] WB_SEL_SLL    = 3'd1;
  localparam logic [2:0] WB_SEL_ORI    = 3'd2;
  localparam logic [2:0] WB_SEL_JMSUB  = 3'd3;
  localparam logic [2:0] WB_SEL_BNEAL  = 3'd4;
  localparam logic [2:0] WB_SEL_BALRN  = 3'd5;

  // One register-file write: data word plus destination index.
  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_RD_W-1:0]   rd;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry valid/ready buffer: an output register backed by one skid entry.
// Latency: 1 cycle from push to pop when the output register is free or draining.
// Backpressure: push_ready drops (registered) only while the skid entry is occupied.
module wb_skid_buf #(
  parameter type entry_t = wb_pkg::wb_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_valid,
  input  entry_t push_data,
  output logic   push_ready,
  output logic   pop_valid,
  output entry_t pop_data,
  input  logic   pop_ready
);

  logic   skid_valid;
  entry_t skid_data;
  logic   out_free;
  logic   push;

  // The output register can take a new entry when empty or being drained this cycle.
  assign out_free   = !pop_valid || pop_ready;
  assign push_ready = !skid_valid;
  assign push       = push_valid && !skid_valid;

  // Output register refills from the skid entry first so ordering stays FIFO;
  // a stalled output diverts an incoming push into the skid entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_valid  <= 1'b0;
      pop_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        pop_valid  <= 1'b1;
        pop_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (push) begin
        pop_valid <= 1'b1;
        pop_data  <= push_data;
      end else begin
        pop_valid <= 1'b0;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= push_data;
    end
  end

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back source selector with $0 filtering and illegal-select reporting.
// Latency: 1 cycle for a legal, non-$0 transfer when the output register is free.
// Backpressure: in_ready (registered) is low while the skid entry holds data; in_* is then ignored.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 6,
  parameter int SEL_W  = 3,
  parameter int RD_W   = 5,
  parameter int ERR_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [RD_W-1:0]         in_rd,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [RD_W-1:0]         out_rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [ERR_W-1:0]        err_count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
  } entry_t;

  localparam logic [SEL_W:0] N_SRC_V = (SEL_W+1)'(N_SRC);

  logic              accept;
  logic              legal;
  logic              push_valid;
  logic              push_ready;
  logic [DATA_W-1:0] sel_data;
  entry_t            push_data;
  entry_t            pop_data;

  assign in_ready   = push_ready;
  assign accept     = in_valid && push_ready;
  assign legal      = {1'b0, in_sel} < N_SRC_V;
  // $0 writes and illegal selects are consumed here and never reach the buffer.
  assign push_valid = accept && legal && (in_rd != '0);
  assign push_data  = '{data: sel_data, rd: in_rd};
  assign out_data   = pop_data.data;
  assign out_rd     = pop_data.rd;

  // Explicit compare per source keeps the part-select in range for any in_sel.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (in_sel == SEL_W'(k)) sel_data = in_data[k*DATA_W +: DATA_W];
    end
  end

  // Illegal-select pulse for the cycle after the accept, plus a saturating tally.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else begin
      sel_err <= accept && !legal;
      if (accept && !legal && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  wb_skid_buf #(.entry_t(entry_t)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (out_valid),
    .pop_data   (pop_data),
    .pop_ready  (out_ready)
  );

endmodule
